// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the LSU memory-access stage.
// Contents: datapath width defaults, FSM state encoding, load func3 codes,
// and a store byte-lane strobe helper.
package lsu_mem_stage_pkg;

    localparam int XLEN_DEF    = 64;
    localparam int ILEN_DEF    = 32;
    localparam int RADDR_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_OUT  = 2'd3
    } lsu_state_t;

    // Load width/sign codes carried in func3.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Moves an LSB-aligned byte mask onto the lanes selected by the address
    // offset; lanes pushed past byte 7 fall off the end.
    function automatic logic [7:0] lane_strobe(input logic [7:0] mask, input logic [2:0] off);
        return mask << off;
    endfunction

endpackage

// File: rtl/lsu_mem_stage_if.sv
// Bus interfaces around the LSU memory-access stage.
//   lsu_ex_if  : execute -> LSU bundle (master = execute, slave = LSU)
//   lsu_mem_if : LSU -> memory request/response port (master = LSU, slave = memory)
//   lsu_wb_if  : LSU -> writeback bundle (master = LSU, slave = WB stage)
interface lsu_ex_if
    import lsu_mem_stage_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int ILEN    = ILEN_DEF,
    parameter int RADDR_W = RADDR_W_DEF
);
    logic               valid;
    logic               ready;
    logic               flush;
    logic [XLEN-1:0]    pc;
    logic [ILEN-1:0]    inst;
    logic [XLEN-1:0]    alures;
    logic [XLEN-1:0]    wdata;
    logic [7:0]         wmask;
    logic [2:0]         func3;
    logic               rflag;
    logic               wflag;
    logic [RADDR_W-1:0] waddr;
    logic               wen;

    modport master (output valid, flush, pc, inst, alures, wdata, wmask, func3,
                           rflag, wflag, waddr, wen,
                    input  ready);
    modport slave  (input  valid, flush, pc, inst, alures, wdata, wmask, func3,
                           rflag, wflag, waddr, wen,
                    output ready);
endinterface

interface lsu_mem_if
    import lsu_mem_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            req_wen;
    logic [XLEN-1:0] req_wdata;
    logic [7:0]      req_wstrb;
    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;

    modport master (output req_valid, req_addr, req_wen, req_wdata, req_wstrb,
                    input  req_ready, rsp_valid, rsp_rdata);
    modport slave  (input  req_valid, req_addr, req_wen, req_wdata, req_wstrb,
                    output req_ready, rsp_valid, rsp_rdata);
endinterface

interface lsu_wb_if
    import lsu_mem_stage_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int ILEN    = ILEN_DEF,
    parameter int RADDR_W = RADDR_W_DEF
);
    logic               valid;
    logic               ready;
    logic [XLEN-1:0]    pc;
    logic [ILEN-1:0]    inst;
    logic [RADDR_W-1:0] waddr;
    logic               wen;
    logic [XLEN-1:0]    wdata;

    modport master (output valid, pc, inst, waddr, wen, wdata, input ready);
    modport slave  (input  valid, pc, inst, waddr, wen, wdata, output ready);
endinterface

// File: rtl/lsu_load_align.sv
// Load data formatter: shifts the addressed bytes of a full memory word down
// to bit 0, then sign- or zero-extends according to func3.
// Ports:
//   rdata  - full memory word as returned by memory
//   offset - byte offset of the access within the word
//   func3  - load width/sign code
//   result - formatted register value
module lsu_load_align
    import lsu_mem_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      offset,
    input  logic [2:0]      func3,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    // Bytes that would come from beyond the top of the word are simply zero
    // after the shift; misaligned accesses are not trapped here.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        result  = '0;
        case (func3)
            F3_LB:   result = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            F3_LH:   result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LW:   result = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            F3_LD:   result = shifted;
            F3_LBU:  result = {{(XLEN-8){1'b0}},  shifted[7:0]};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, shifted[15:0]};
            F3_LWU:  result = {{(XLEN-32){1'b0}}, shifted[31:0]};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-access stage downstream of execute. Accepts one execute bundle at a
// time, performs at most one outstanding load or store on the memory port,
// formats load data and presents a registered writeback bundle. Non-memory
// instructions reach writeback one cycle after acceptance.
// Ports:
//   clock, reset - clock and asynchronous active-high reset
//   ex           - execute bundle in (valid/ready, flush, pc, inst, operands)
//   mem          - single-outstanding memory request/response port
//   wb           - registered writeback bundle out (valid/ready)
module lsu_mem_stage
    import lsu_mem_stage_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int ILEN    = ILEN_DEF,
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic      clock,
    input  logic      reset,
    lsu_ex_if.slave   ex,
    lsu_mem_if.master mem,
    lsu_wb_if.master  wb
);

    lsu_state_t state, state_next;

    // Bundle held for the duration of a memory transaction.
    logic [XLEN-1:0]    op_pc;
    logic [ILEN-1:0]    op_inst;
    logic [XLEN-1:0]    op_alures;
    logic [XLEN-1:0]    op_wdata;
    logic [7:0]         op_wmask;
    logic [2:0]         op_func3;
    logic               op_store;
    logic [RADDR_W-1:0] op_waddr;
    logic               op_wen;

    // Writeback output register.
    logic [XLEN-1:0]    out_pc;
    logic [ILEN-1:0]    out_inst;
    logic [RADDR_W-1:0] out_waddr;
    logic               out_wen;
    logic [XLEN-1:0]    out_wdata;

    logic               ex_ready_c;
    logic               req_valid_c;
    logic               wb_valid_c;
    logic               accept;
    logic               is_mem;
    logic               take_mem;
    logic               take_alu;
    logic               take_rsp;
    logic [2:0]         off;
    logic [XLEN-1:0]    load_data;

    // A bundle can be taken when the output register is empty or is being
    // drained this very cycle; derived from state only, so no comb loop.
    assign accept   = ex.valid && ((state == ST_IDLE) || ((state == ST_OUT) && wb.ready));
    assign is_mem   = ex.rflag || ex.wflag;
    assign take_mem = accept && !ex.flush && is_mem;
    assign take_alu = accept && !ex.flush && !is_mem;
    assign take_rsp = (state == ST_RESP) && mem.rsp_valid;
    assign off      = op_alures[2:0];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs. IDLE and OUT share the acceptance
    // path so back-to-back bundles behave exactly as if taken from IDLE.
    always_comb begin
        state_next  = state;
        ex_ready_c  = 1'b0;
        req_valid_c = 1'b0;
        wb_valid_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                ex_ready_c = 1'b1;
                if (accept && !ex.flush) begin
                    state_next = is_mem ? ST_REQ : ST_OUT;
                end
            end
            ST_REQ: begin
                req_valid_c = 1'b1;
                if (mem.req_ready) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (mem.rsp_valid) begin
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                wb_valid_c = 1'b1;
                ex_ready_c = wb.ready;
                if (accept && !ex.flush) begin
                    state_next = is_mem ? ST_REQ : ST_OUT;
                end else if (wb.ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture the memory bundle on acceptance; it stays put until the next
    // memory instruction, which keeps the request fields stable under stall.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_pc     <= '0;
            op_inst   <= '0;
            op_alures <= '0;
            op_wdata  <= '0;
            op_wmask  <= '0;
            op_func3  <= '0;
            op_store  <= 1'b0;
            op_waddr  <= '0;
            op_wen    <= 1'b0;
        end else if (take_mem) begin
            op_pc     <= ex.pc;
            op_inst   <= ex.inst;
            op_alures <= ex.alures;
            op_wdata  <= ex.wdata;
            op_wmask  <= ex.wmask;
            op_func3  <= ex.func3;
            op_store  <= ex.wflag;
            op_waddr  <= ex.waddr;
            op_wen    <= ex.wen;
        end
    end

    lsu_load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .rdata  (mem.rsp_rdata),
        .offset (off),
        .func3  (op_func3),
        .result (load_data)
    );

    // Output register: loaded from execute for ALU ops, or from the memory
    // response. Stores report the ALU result and never write a register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_pc    <= '0;
            out_inst  <= '0;
            out_waddr <= '0;
            out_wen   <= 1'b0;
            out_wdata <= '0;
        end else if (take_alu) begin
            out_pc    <= ex.pc;
            out_inst  <= ex.inst;
            out_waddr <= ex.waddr;
            out_wen   <= ex.wen;
            out_wdata <= ex.alures;
        end else if (take_rsp) begin
            out_pc    <= op_pc;
            out_inst  <= op_inst;
            out_waddr <= op_waddr;
            out_wen   <= op_store ? 1'b0 : op_wen;
            out_wdata <= op_store ? op_alures : load_data;
        end
    end

    assign ex.ready      = ex_ready_c;

    assign mem.req_valid = req_valid_c;
    assign mem.req_addr  = {op_alures[XLEN-1:3], 3'b000};
    assign mem.req_wen   = op_store;
    assign mem.req_wdata = op_wdata << {off, 3'b000};
    assign mem.req_wstrb = lane_strobe(op_wmask, off);

    assign wb.valid      = wb_valid_c;
    assign wb.pc         = out_pc;
    assign wb.inst       = out_inst;
    assign wb.waddr      = out_waddr;
    assign wb.wen        = out_wen;
    assign wb.wdata      = out_wdata;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Self-checking bench for lsu_mem_stage. Inputs change on the falling edge
// and outputs are sampled 1 time unit later, away from the rising edge.
module tb_lsu_mem_stage;
    import lsu_mem_stage_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    lsu_ex_if  #(.XLEN(64), .ILEN(32), .RADDR_W(5)) ex_bus ();
    lsu_mem_if #(.XLEN(64))                         mem_bus ();
    lsu_wb_if  #(.XLEN(64), .ILEN(32), .RADDR_W(5)) wb_bus ();

    lsu_mem_stage #(.XLEN(64), .ILEN(32), .RADDR_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .ex    (ex_bus),
        .mem   (mem_bus),
        .wb    (wb_bus)
    );

    // Observations gathered by the driver tasks.
    logic        o_accept_ready;
    logic [63:0] o_req_addr, o_req_wdata;
    logic [7:0]  o_req_wstrb;
    logic        o_req_wen;
    bit          o_req_missing, o_req_unstable, o_exready_high, o_wb_early, o_req_extra;
    logic [63:0] o_wb_pc, o_wb_wdata;
    logic [31:0] o_wb_inst;
    logic [4:0]  o_wb_waddr;
    logic        o_wb_wen;
    bit          o_wb_missing, o_wb_unstable, o_wb_exready_bad, o_req_in_out, o_wb_after;

    // Reference: pick the addressed bytes one by one, then extend by width.
    function automatic logic [63:0] ref_load(input logic [63:0] word, input logic [63:0] addr,
                                             input logic [2:0] f3);
        int          o;
        int          size;
        logic [63:0] v;
        if (f3 == 3'b111) return 64'd0;
        o    = int'(addr % 64'd8);
        size = 1 << f3[1:0];
        v    = 64'd0;
        for (int i = 0; i < size; i++) begin
            if (o + i < 8) v[8*i +: 8] = word[8*(o+i) +: 8];
        end
        if (!f3[2] && size < 8 && v[8*size-1]) begin
            for (int b = 8 * size; b < 64; b++) v[b] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [7:0] ref_strb(input logic [7:0] mask, input logic [63:0] addr);
        int         o;
        logic [7:0] s;
        o = int'(addr % 64'd8);
        s = 8'd0;
        for (int i = 0; i < 8; i++) begin
            if (mask[i] && o + i < 8) s[o+i] = 1'b1;
        end
        return s;
    endfunction

    function automatic logic [63:0] ref_wdata(input logic [63:0] data, input logic [63:0] addr);
        int          o;
        logic [63:0] d;
        o = int'(addr % 64'd8);
        d = 64'd0;
        for (int i = 0; i < 8; i++) begin
            if (o + i < 8) d[8*(o+i) +: 8] = data[8*i +: 8];
        end
        return d;
    endfunction

    task automatic send_bundle(input logic [63:0] pc, input logic [31:0] inst,
                               input logic [63:0] alures, input logic [63:0] wdata,
                               input logic [7:0] mask, input logic [2:0] f3,
                               input logic rflag, input logic wflag, input logic flush,
                               input logic [4:0] waddr, input logic wen, input logic wbr);
        @(negedge clock);
        mem_bus.req_ready = 1'b0;
        mem_bus.rsp_valid = 1'b0;
        wb_bus.ready      = wbr;
        ex_bus.valid      = 1'b1;
        ex_bus.pc         = pc;
        ex_bus.inst       = inst;
        ex_bus.alures     = alures;
        ex_bus.wdata      = wdata;
        ex_bus.wmask      = mask;
        ex_bus.func3      = f3;
        ex_bus.rflag      = rflag;
        ex_bus.wflag      = wflag;
        ex_bus.flush      = flush;
        ex_bus.waddr      = waddr;
        ex_bus.wen        = wen;
        #1;
        o_accept_ready = ex_bus.ready;
    endtask

    // Plays the memory: holds off req_ready, then answers after rsp_wait idle
    // cycles. Stray responses during REQ and scrambled ex inputs must not matter.
    task automatic serve_mem(input int req_wait, input int rsp_wait, input logic [63:0] rdata);
        o_req_missing = 0; o_req_unstable = 0; o_exready_high = 0; o_wb_early = 0; o_req_extra = 0;
        for (int i = 0; i <= req_wait; i++) begin
            @(negedge clock);
            ex_bus.valid      = 1'b0;
            ex_bus.alures     = {$urandom, $urandom};
            ex_bus.wdata      = {$urandom, $urandom};
            wb_bus.ready      = 1'b0;
            mem_bus.req_ready = (i == req_wait);
            mem_bus.rsp_valid = 1'($urandom_range(0, 1));
            mem_bus.rsp_rdata = {$urandom, $urandom};
            #1;
            if (mem_bus.req_valid !== 1'b1) o_req_missing = 1;
            if (ex_bus.ready !== 1'b0) o_exready_high = 1;
            if (wb_bus.valid !== 1'b0) o_wb_early = 1;
            if (i == 0) begin
                o_req_addr  = mem_bus.req_addr;
                o_req_wdata = mem_bus.req_wdata;
                o_req_wstrb = mem_bus.req_wstrb;
                o_req_wen   = mem_bus.req_wen;
            end else if ({o_req_addr, o_req_wdata, o_req_wstrb, o_req_wen} !==
                         {mem_bus.req_addr, mem_bus.req_wdata, mem_bus.req_wstrb, mem_bus.req_wen}) begin
                o_req_unstable = 1;
            end
        end
        for (int i = 0; i <= rsp_wait; i++) begin
            @(negedge clock);
            mem_bus.req_ready = 1'($urandom_range(0, 1));
            mem_bus.rsp_valid = (i == rsp_wait);
            mem_bus.rsp_rdata = (i == rsp_wait) ? rdata : {$urandom, $urandom};
            #1;
            if (mem_bus.req_valid !== 1'b0) o_req_extra = 1;
            if (ex_bus.ready !== 1'b0) o_exready_high = 1;
            if (wb_bus.valid !== 1'b0) o_wb_early = 1;
        end
    endtask

    // Holds wb_ready low for wb_wait cycles, then takes one transfer and checks
    // for stray responses in IDLE afterwards.
    task automatic drain_wb(input int wb_wait);
        o_wb_missing = 0; o_wb_unstable = 0; o_wb_exready_bad = 0; o_req_in_out = 0;
        for (int i = 0; i <= wb_wait; i++) begin
            @(negedge clock);
            ex_bus.valid      = 1'b0;
            mem_bus.req_ready = 1'b0;
            mem_bus.rsp_valid = 1'b0;
            wb_bus.ready      = (i == wb_wait);
            #1;
            if (wb_bus.valid !== 1'b1) o_wb_missing = 1;
            if (mem_bus.req_valid !== 1'b0) o_req_in_out = 1;
            if (ex_bus.ready !== (i == wb_wait)) o_wb_exready_bad = 1;
            if (i == 0) begin
                o_wb_pc = wb_bus.pc; o_wb_inst = wb_bus.inst; o_wb_waddr = wb_bus.waddr;
                o_wb_wen = wb_bus.wen; o_wb_wdata = wb_bus.wdata;
            end else if ({o_wb_pc, o_wb_inst, o_wb_waddr, o_wb_wen, o_wb_wdata} !==
                         {wb_bus.pc, wb_bus.inst, wb_bus.waddr, wb_bus.wen, wb_bus.wdata}) begin
                o_wb_unstable = 1;
            end
        end
        @(negedge clock);
        wb_bus.ready      = 1'b0;
        mem_bus.rsp_valid = 1'b1;
        mem_bus.rsp_rdata = {$urandom, $urandom};
        #1;
        o_wb_after = wb_bus.valid;
        @(negedge clock);
        mem_bus.rsp_valid = 1'b0;
        #1;
        if (wb_bus.valid !== 1'b0) o_wb_after = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (ex_bus.ready !== 1'b1) begin
            failures++; $display("[TB] FAIL reset_ex_ready: got %b want 1", ex_bus.ready);
        end
        checks++;
        if ({mem_bus.req_valid, mem_bus.req_wen, mem_bus.req_addr, mem_bus.req_wdata, mem_bus.req_wstrb} !== '0) begin
            failures++; $display("[TB] FAIL reset_mem_outputs: valid=%b addr=%h want all 0", mem_bus.req_valid, mem_bus.req_addr);
        end
        checks++;
        if ({wb_bus.valid, wb_bus.pc, wb_bus.inst, wb_bus.waddr, wb_bus.wen, wb_bus.wdata} !== '0) begin
            failures++; $display("[TB] FAIL reset_wb_outputs: valid=%b wdata=%h want all 0", wb_bus.valid, wb_bus.wdata);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_non_mem();
        logic [63:0] alu, pc;
        logic [31:0] inst;
        logic [4:0]  wa;
        logic        we;
        for (int n = 0; n < 8; n++) begin
            alu  = (n == 0) ? 64'h1234 : {$urandom, $urandom};
            pc   = {$urandom, $urandom};
            inst = (n == 0) ? 32'h00a50533 : $urandom;
            wa   = (n == 0) ? 5'd5 : 5'($urandom_range(0, 31));
            we   = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            send_bundle(pc, inst, alu, {$urandom, $urandom}, 8'hFF, 3'($urandom_range(0, 7)),
                        1'b0, 1'b0, 1'b0, wa, we, 1'b0);
            drain_wb((n == 0) ? 0 : $urandom_range(0, 2));
            checks++;
            if (o_accept_ready !== 1'b1 || o_wb_missing || o_wb_unstable) begin
                failures++; $display("[TB] FAIL nonmem_latency[%0d]: ready=%b missing=%0d unstable=%0d want 1/0/0", n, o_accept_ready, o_wb_missing, o_wb_unstable);
            end
            checks++;
            if ({o_wb_wdata, o_wb_pc, o_wb_inst, o_wb_waddr, o_wb_wen} !== {alu, pc, inst, wa, we}) begin
                failures++; $display("[TB] FAIL nonmem_bundle[%0d]: wdata=%h waddr=%0d wen=%b want %h %0d %b", n, o_wb_wdata, o_wb_waddr, o_wb_wen, alu, wa, we);
            end
            checks++;
            if (o_req_in_out || o_wb_after || o_wb_exready_bad) begin
                failures++; $display("[TB] FAIL nonmem_protocol[%0d]: req=%0d after=%0d exready_bad=%0d want 0", n, o_req_in_out, o_wb_after, o_wb_exready_bad);
            end
        end
    endtask

    // Shared body for loads and stores; the expected values come from the
    // byte-level reference functions above.
    task automatic test_mem_op(input string name, input int n, input logic store,
                               input logic [63:0] alu, input logic [2:0] f3, input logic [7:0] mask,
                               input logic [63:0] sdata, input logic [63:0] rdata,
                               input int rw, input int sw, input int ww);
        logic [63:0] pc;
        logic [31:0] inst;
        logic [4:0]  wa;
        logic        we;
        logic [63:0] exp_wb;
        pc   = {$urandom, $urandom};
        inst = $urandom;
        wa   = 5'($urandom_range(1, 31));
        we   = 1'b1;
        send_bundle(pc, inst, alu, sdata, mask, f3, !store, store, 1'b0, wa, we, 1'b0);
        serve_mem(rw, sw, rdata);
        drain_wb(ww);
        exp_wb = store ? alu : ref_load(rdata, alu, f3);
        checks++;
        if ({o_req_addr, o_req_wen} !== {alu - (alu % 64'd8), store}) begin
            failures++; $display("[TB] FAIL %s_req_addr[%0d]: addr=%h wen=%b want %h %b", name, n, o_req_addr, o_req_wen, alu - (alu % 64'd8), store);
        end
        if (store) begin
            checks++;
            if ({o_req_wstrb, o_req_wdata} !== {ref_strb(mask, alu), ref_wdata(sdata, alu)}) begin
                failures++; $display("[TB] FAIL %s_lanes[%0d]: wstrb=%h wdata=%h want %h %h", name, n, o_req_wstrb, o_req_wdata, ref_strb(mask, alu), ref_wdata(sdata, alu));
            end
        end
        checks++;
        if ({o_wb_wdata, o_wb_wen, o_wb_waddr, o_wb_pc, o_wb_inst} !== {exp_wb, !store, wa, pc, inst}) begin
            failures++; $display("[TB] FAIL %s_wb[%0d]: wdata=%h wen=%b waddr=%0d want %h %b %0d", name, n, o_wb_wdata, o_wb_wen, o_wb_waddr, exp_wb, !store, wa);
        end
        checks++;
        if ({o_accept_ready, o_req_missing, o_req_unstable, o_exready_high, o_wb_early, o_req_extra} !== 6'b100000) begin
            failures++; $display("[TB] FAIL %s_req_protocol[%0d]: rdy/miss/unst/exrdy/early/extra=%b want 100000", name, n,
                {o_accept_ready, o_req_missing, o_req_unstable, o_exready_high, o_wb_early, o_req_extra});
        end
        checks++;
        if ({o_wb_missing, o_wb_unstable, o_wb_exready_bad, o_req_in_out, o_wb_after} !== 5'b00000) begin
            failures++; $display("[TB] FAIL %s_wb_protocol[%0d]: miss/unst/exrdy/req/after=%b want 00000", name, n,
                {o_wb_missing, o_wb_unstable, o_wb_exready_bad, o_req_in_out, o_wb_after});
        end
    endtask

    task automatic test_loads();
        test_mem_op("lb_sign", 0, 1'b0, 64'h80000003, F3_LB, 8'h01, 64'h0, 64'h00000000_80FF0000, 0, 0, 0);
        test_mem_op("lwu", 0, 1'b0, 64'h80000004, F3_LWU, 8'h0F, 64'h0, 64'h89ABCDEF_00000000, 0, 0, 0);
        for (int n = 0; n < 24; n++) begin
            test_mem_op("load_rand", n, 1'b0, {$urandom, $urandom}, 3'($urandom_range(0, 7)), 8'h00,
                        {$urandom, $urandom}, {$urandom, $urandom},
                        $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1));
        end
    endtask

    task automatic test_stores();
        logic [7:0] masks [4];
        masks[0] = 8'h01; masks[1] = 8'h03; masks[2] = 8'h0F; masks[3] = 8'hFF;
        test_mem_op("sh", 0, 1'b1, 64'h80000006, 3'b001, 8'h03, 64'hBEEF, 64'h0, 0, 0, 0);
        for (int n = 0; n < 16; n++) begin
            test_mem_op("store_rand", n, 1'b1, {$urandom, $urandom}, 3'($urandom_range(0, 3)),
                        masks[$urandom_range(0, 3)], {$urandom, $urandom}, {$urandom, $urandom},
                        $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 1));
        end
    endtask

    task automatic test_backpressure();
        test_mem_op("bp_load", 0, 1'b0, 64'h0000_0040_0000_1005, F3_LH, 8'h00, 64'h0,
                    64'h1122_8877_5566_3344, 4, 2, 3);
        test_mem_op("bp_store", 0, 1'b1, 64'h0000_0040_0000_2001, 3'b010, 8'h0F,
                    64'hCAFE_F00D_1234_5678, 64'h0, 4, 1, 3);
    endtask

    task automatic test_flush();
        bit seen_req, seen_wb, lost_ready;
        send_bundle(64'h100, 32'h0, 64'h80000010, 64'h0, 8'hFF, F3_LD, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
        checks++;
        if (o_accept_ready !== 1'b1) begin
            failures++; $display("[TB] FAIL flush_accept: ex_ready=%b want 1", o_accept_ready);
        end
        seen_req = 0; seen_wb = 0; lost_ready = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            ex_bus.valid = 1'b0;
            mem_bus.req_ready = 1'b1;
            #1;
            if (mem_bus.req_valid !== 1'b0) seen_req = 1;
            if (wb_bus.valid !== 1'b0) seen_wb = 1;
            if (ex_bus.ready !== 1'b1) lost_ready = 1;
        end
        mem_bus.req_ready = 1'b0;
        checks++;
        if ({seen_req, seen_wb, lost_ready} !== 3'b000) begin
            failures++; $display("[TB] FAIL flush_no_activity: req/wb/notready=%b want 000", {seen_req, seen_wb, lost_ready});
        end
    endtask

    task automatic test_reset_in_resp();
        send_bundle(64'h200, 32'h3, 64'h80000008, 64'h0, 8'hFF, F3_LD, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
        @(negedge clock);
        ex_bus.valid = 1'b0;
        mem_bus.req_ready = 1'b1;
        @(negedge clock);
        mem_bus.req_ready = 1'b0;
        #1;
        checks++;
        if ({mem_bus.req_valid, ex_bus.ready, wb_bus.valid} !== 3'b000) begin
            failures++; $display("[TB] FAIL resp_wait_state: req/exrdy/wb=%b want 000", {mem_bus.req_valid, ex_bus.ready, wb_bus.valid});
        end
        reset = 1'b1;
        #1;
        checks++;
        if (ex_bus.ready !== 1'b1 ||
            {mem_bus.req_valid, mem_bus.req_wen, mem_bus.req_addr, mem_bus.req_wdata, mem_bus.req_wstrb,
             wb_bus.valid, wb_bus.pc, wb_bus.inst, wb_bus.waddr, wb_bus.wen, wb_bus.wdata} !== '0) begin
            failures++; $display("[TB] FAIL reset_in_resp: ex_ready=%b req_addr=%h wb_valid=%b want 1/0/0", ex_bus.ready, mem_bus.req_addr, wb_bus.valid);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        mem_bus.rsp_valid = 1'b1;
        mem_bus.rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        checks++;
        if ({ex_bus.ready, mem_bus.req_valid, wb_bus.valid} !== 3'b100) begin
            failures++; $display("[TB] FAIL idle_after_reset: exrdy/req/wb=%b want 100", {ex_bus.ready, mem_bus.req_valid, wb_bus.valid});
        end
        send_bundle(64'h300, 32'h4, 64'h5A5A, 64'h0, 8'hFF, 3'b000, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0);
        drain_wb(0);
        checks++;
        if ({o_wb_missing, o_wb_wdata, o_wb_waddr} !== {1'b0, 64'h5A5A, 5'd3}) begin
            failures++; $display("[TB] FAIL recover_after_reset: missing=%0d wdata=%h waddr=%0d want 0 5a5a 3", o_wb_missing, o_wb_wdata, o_wb_waddr);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] alu [6];
        logic [63:0] rdata;
        for (int k = 0; k < 6; k++) alu[k] = {$urandom, $urandom};
        send_bundle(64'h400, 32'h5, alu[0], 64'h0, 8'hFF, 3'b000, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b0);
        for (int k = 1; k < 6; k++) begin
            send_bundle(64'h400 + 64'(4 * k), 32'h5, alu[k], 64'h0, 8'hFF, 3'b000, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1);
            checks++;
            if ({wb_bus.valid, wb_bus.wdata, o_accept_ready} !== {1'b1, alu[k-1], 1'b1}) begin
                failures++; $display("[TB] FAIL b2b_stream[%0d]: valid=%b wdata=%h ready=%b want 1 %h 1", k, wb_bus.valid, wb_bus.wdata, o_accept_ready, alu[k-1]);
            end
        end
        // Hand the last ALU result over while a load is accepted in the same cycle.
        rdata = {$urandom, $urandom};
        send_bundle(64'h500, 32'h6, 64'h1000_0002, 64'h0, 8'h00, F3_LHU, 1'b1, 1'b0, 1'b0, 5'd2, 1'b1, 1'b1);
        checks++;
        if ({wb_bus.valid, wb_bus.wdata, o_accept_ready} !== {1'b1, alu[5], 1'b1}) begin
            failures++; $display("[TB] FAIL b2b_into_load: valid=%b wdata=%h ready=%b want 1 %h 1", wb_bus.valid, wb_bus.wdata, o_accept_ready, alu[5]);
        end
        serve_mem(0, 0, rdata);
        drain_wb(0);
        checks++;
        if ({o_req_missing, o_wb_early, o_wb_missing, o_wb_wdata, o_wb_after} !==
            {1'b0, 1'b0, 1'b0, ref_load(rdata, 64'h1000_0002, F3_LHU), 1'b0}) begin
            failures++; $display("[TB] FAIL b2b_load_result: wdata=%h miss=%0d early=%0d want %h", o_wb_wdata, o_wb_missing, o_wb_early, ref_load(rdata, 64'h1000_0002, F3_LHU));
        end
    endtask

    initial begin
        reset             = 1'b1;
        ex_bus.valid      = 1'b0; ex_bus.flush = 1'b0; ex_bus.pc = '0; ex_bus.inst = '0;
        ex_bus.alures     = '0;   ex_bus.wdata = '0;   ex_bus.wmask = '0; ex_bus.func3 = '0;
        ex_bus.rflag      = 1'b0; ex_bus.wflag = 1'b0; ex_bus.waddr = '0; ex_bus.wen = 1'b0;
        mem_bus.req_ready = 1'b0; mem_bus.rsp_valid = 1'b0; mem_bus.rsp_rdata = '0;
        wb_bus.ready      = 1'b0;
        test_reset();
        test_non_mem();
        test_loads();
        test_stores();
        test_backpressure();
        test_flush();
        test_reset_in_resp();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
